// File: rtl/six_bcd_adder_if.sv
// rtl/six_bcd_adder_if.sv - operand/result bundle for the registered BCD adder
interface six_bcd_adder_if #(
  parameter int DIGITS = 1
);
  logic [4*DIGITS-1:0] A;
  logic [4*DIGITS-1:0] B;
  logic                C;
  logic [4*DIGITS-1:0] F;
  logic                COUT;

  modport master (
    output A,
    output B,
    output C,
    input  F,
    input  COUT
  );

  modport slave (
    input  A,
    input  B,
    input  C,
    output F,
    output COUT
  );
endinterface

// File: rtl/six_bcd_adder.sv
// rtl/six_bcd_adder.sv - registered multi-digit 8421-BCD adder with carry in/out
module six_bcd_adder #(
  parameter int DIGITS = 1
) (
  input  logic          clk,
  input  logic          rst,
  six_bcd_adder_if.slave bus
);

  logic [4*DIGITS-1:0] sum_nxt;
  logic                cout_nxt;
  logic                carry;
  logic [4:0]          z;
  logic [4:0]          zc;

  // Carry ripples through every digit within the cycle; non-BCD digits get the same +6 rule.
  always_comb begin
    sum_nxt  = '0;
    carry    = bus.C;
    z        = '0;
    zc       = '0;
    for (int i = 0; i < DIGITS; i++) begin
      z = {1'b0, bus.A[4*i +: 4]} + {1'b0, bus.B[4*i +: 4]} + {4'b0000, carry};
      zc = z + 5'd6;
      if (z > 5'd9) begin
        sum_nxt[4*i +: 4] = zc[3:0];
        carry             = 1'b1;
      end else begin
        sum_nxt[4*i +: 4] = z[3:0];
        carry             = 1'b0;
      end
    end
    cout_nxt = carry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.F    <= '0;
      bus.COUT <= 1'b0;
    end else begin
      bus.F    <= sum_nxt;
      bus.COUT <= cout_nxt;
    end
  end

endmodule

// File: tb/tb_six_bcd_adder.sv
// tb/tb_six_bcd_adder.sv - directed self-checking bench for six_bcd_adder
module tb_six_bcd_adder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [3:0] prev_f;
  logic       prev_c;

  six_bcd_adder_if #(.DIGITS(1)) u_if1 ();
  six_bcd_adder_if #(.DIGITS(2)) u_if2 ();

  six_bcd_adder #(.DIGITS(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (u_if1.slave)
  );

  six_bcd_adder #(.DIGITS(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (u_if2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after an active edge: drive, confirm outputs hold until the next edge, then check.
  task automatic step1(input string tag, input logic [3:0] a, input logic [3:0] b, input logic c,
                       input logic [3:0] ef, input logic ec);
    u_if1.A = a;
    u_if1.B = b;
    u_if1.C = c;
    #3;
    check({tag, "_hold_f"}, {28'd0, u_if1.F}, {28'd0, prev_f});
    check({tag, "_hold_c"}, {31'd0, u_if1.COUT}, {31'd0, prev_c});
    @(posedge clk);
    #1;
    check({tag, "_f"}, {28'd0, u_if1.F}, {28'd0, ef});
    check({tag, "_c"}, {31'd0, u_if1.COUT}, {31'd0, ec});
    prev_f = ef;
    prev_c = ec;
  endtask

  task automatic step2(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] ef, input logic ec);
    u_if2.A = a;
    u_if2.B = b;
    u_if2.C = c;
    @(posedge clk);
    #1;
    check({tag, "_f"}, {24'd0, u_if2.F}, {24'd0, ef});
    check({tag, "_c"}, {31'd0, u_if2.COUT}, {31'd0, ec});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    u_if1.A = 4'd3;
    u_if1.B = 4'd6;
    u_if1.C = 1'b0;
    u_if2.A = 8'h45;
    u_if2.B = 8'h38;
    u_if2.C = 1'b1;

    #1;
    check("rst_pre_edge_f", {28'd0, u_if1.F}, 32'd0);
    check("rst_pre_edge_c", {31'd0, u_if1.COUT}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_f", {28'd0, u_if1.F}, 32'd0);
      check("rst_c", {31'd0, u_if1.COUT}, 32'd0);
      check("rst2_f", {24'd0, u_if2.F}, 32'd0);
    end

    rst    = 1'b0;
    prev_f = 4'd0;
    prev_c = 1'b0;
    step1("zero",      4'd0,  4'd0,  1'b0, 4'd0, 1'b0);
    step1("z9",        4'd3,  4'd6,  1'b0, 4'd9, 1'b0);
    step1("z10",       4'd3,  4'd6,  1'b1, 4'd0, 1'b1);
    step1("z15",       4'd8,  4'd7,  1'b0, 4'd5, 1'b1);
    step1("z16",       4'd8,  4'd7,  1'b1, 4'd6, 1'b1);
    step1("nonbcd18",  4'd12, 4'd6,  1'b0, 4'd8, 1'b1);
    step1("max19",     4'd9,  4'd9,  1'b1, 4'd9, 1'b1);
    step1("ff_c0",     4'd15, 4'd15, 1'b0, 4'd4, 1'b1);
    step1("ff_c1",     4'd15, 4'd15, 1'b1, 4'd5, 1'b1);
    step1("cin_only",  4'd0,  4'd0,  1'b1, 4'd1, 1'b0);
    step1("pre_rst",   4'd8,  4'd7,  1'b1, 4'd6, 1'b1);

    // Asynchronous reset between edges must clear outputs before the next edge.
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_f", {28'd0, u_if1.F}, 32'd0);
    check("async_rst_c", {31'd0, u_if1.COUT}, 32'd0);
    check("async_rst2_f", {24'd0, u_if2.F}, 32'd0);
    @(posedge clk);
    #1;
    check("async_hold_f", {28'd0, u_if1.F}, 32'd0);
    rst    = 1'b0;
    prev_f = 4'd0;
    prev_c = 1'b0;
    step1("post_rst",  4'd3,  4'd6,  1'b0, 4'd9, 1'b0);

    step2("d2_9901",   8'h99, 8'h01, 1'b0, 8'h00, 1'b1);
    step2("d2_4538",   8'h45, 8'h38, 1'b1, 8'h84, 1'b0);
    step2("d2_9999",   8'h99, 8'h99, 1'b1, 8'h99, 1'b1);
    step2("d2_0509",   8'h05, 8'h09, 1'b0, 8'h14, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
